// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sb
// Description : Parametrised register file with two combinational read ports,
//               one clocked byte-enabled write port, write-to-read bypass and
//               a per-register pending (scoreboard) bit for RAW detection.
// Ports       : clk, rst_n         - clock, asynchronous active-low reset
//               wr, rd, write_data, be
//                                  - write strobe, address, data, byte enables
//               claim, claim_addr  - mark a register pending
//               r1, r2             - read addresses
//               out1, out2         - read data (combinational, bypassed)
//               busy1, busy2       - pending status of r1 / r2
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic [ADDR_W-1:0]     rd,
    input  logic [DATA_W-1:0]     write_data,
    input  logic [DATA_W/8-1:0]   be,
    input  logic                  claim,
    input  logic [ADDR_W-1:0]     claim_addr,
    input  logic [ADDR_W-1:0]     r1,
    input  logic [ADDR_W-1:0]     r2,
    output logic [DATA_W-1:0]     out1,
    output logic [DATA_W-1:0]     out2,
    output logic                  busy1,
    output logic                  busy2
);

    localparam int c_DEPTH  = 2 ** ADDR_W;
    localparam int c_NBYTES = DATA_W / 8;

    logic [DATA_W-1:0]  mem_q [c_DEPTH];
    logic [DATA_W-1:0]  mem_d [c_DEPTH];
    logic [c_DEPTH-1:0] busy_q;
    logic [c_DEPTH-1:0] busy_d;

    logic [DATA_W-1:0]  w_be_mask;
    logic [DATA_W-1:0]  w_wr_merged;
    logic               w_wr_ok;
    logic               w_claim_ok;

    // Accesses to a hard-wired zero register are dropped at the source, so the
    // bypass and the storage update both see the same qualified strobe.
    assign w_wr_ok    = rst_n && wr    && !((ZERO_REG != 0) && (rd == '0));
    assign w_claim_ok = rst_n && claim && !((ZERO_REG != 0) && (claim_addr == '0));

    always_comb begin
        w_be_mask = '0;
        for (int i = 0; i < c_NBYTES; i++) begin
            w_be_mask[8*i +: 8] = {8{be[i]}};
        end
    end

    // Value reg[rd] will hold after this edge; also the bypass value for any
    // read port addressing rd.
    assign w_wr_merged = (mem_q[rd] & ~w_be_mask) | (write_data & w_be_mask);

    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (w_wr_ok) begin
            mem_d[rd]  = w_wr_merged;
            busy_d[rd] = 1'b0;
        end
        // Claim is applied after the write so a same-address claim wins.
        if (w_claim_ok) begin
            busy_d[claim_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '{default: '0};
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;
        logic              w_busy;

        assign w_addr = (p == 0) ? r1 : r2;

        always_comb begin
            w_data = mem_q[w_addr];
            w_busy = busy_q[w_addr];
            if (w_wr_ok && (rd == w_addr)) begin
                w_data = w_wr_merged;
                // Retiring write clears the hazard now, unless the same
                // register is being re-claimed in this very cycle.
                if (!(w_claim_ok && (claim_addr == w_addr))) begin
                    w_busy = 1'b0;
                end
            end
            if (!rst_n || ((ZERO_REG != 0) && (w_addr == '0))) begin
                w_data = '0;
                w_busy = 1'b0;
            end
        end

        if (p == 0) begin : g_out1
            assign out1  = w_data;
            assign busy1 = w_busy;
        end else begin : g_out2
            assign out2  = w_data;
            assign busy2 = w_busy;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_sb
// Description : Self-checking bench for reg_file_sb. Three instances:
//               A = 32x32 with zero register, B = 32x32 without zero register
//               (shares A's inputs), C = 8x16 with zero register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

    logic        clk;
    logic        rst_n;

    logic        wr, claim;
    logic [4:0]  rd, caddr, r1, r2;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] oa1, oa2, ob1, ob2;
    logic        ba1, ba2, bb1, bb2;

    logic        wr_c, claim_c;
    logic [2:0]  rd_c, caddr_c, r1_c, r2_c;
    logic [15:0] wdata_c;
    logic [1:0]  be_c;
    logic [15:0] oc1, oc2;
    logic        bc1, bc2;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] ref_ma [32];
    logic [31:0] ref_mb [32];
    logic        ref_ba [32];
    logic        ref_bb [32];
    logic [15:0] ref_mc [8];
    logic        ref_bc [8];

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_a (
        .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .write_data(wdata), .be(be),
        .claim(claim), .claim_addr(caddr), .r1(r1), .r2(r2),
        .out1(oa1), .out2(oa2), .busy1(ba1), .busy2(ba2));

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_b (
        .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .write_data(wdata), .be(be),
        .claim(claim), .claim_addr(caddr), .r1(r1), .r2(r2),
        .out1(ob1), .out2(ob2), .busy1(bb1), .busy2(bb2));

    reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) u_c (
        .clk(clk), .rst_n(rst_n), .wr(wr_c), .rd(rd_c), .write_data(wdata_c), .be(be_c),
        .claim(claim_c), .claim_addr(caddr_c), .r1(r1_c), .r2(r2_c),
        .out1(oc1), .out2(oc2), .busy1(bc1), .busy2(bc2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // ---------------- model ----------------
    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] en);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] exp_out_ab(input bit z, input logic [4:0] a);
        logic [31:0] stored;
        stored = z ? ref_ma[a] : ref_mb[a];
        if (!rst_n) return 32'h0;
        if (z && a == 5'd0) return 32'h0;
        if (wr && rd == a) return merge(stored, wdata, be);
        return stored;
    endfunction

    function automatic logic exp_busy_ab(input bit z, input logic [4:0] a);
        logic stored;
        stored = z ? ref_ba[a] : ref_bb[a];
        if (!rst_n) return 1'b0;
        if (z && a == 5'd0) return 1'b0;
        if (wr && rd == a) return (claim && caddr == a) ? stored : 1'b0;
        return stored;
    endfunction

    function automatic logic [15:0] exp_out_c(input logic [2:0] a);
        logic [31:0] m;
        if (!rst_n) return 16'h0;
        if (a == 3'd0) return 16'h0;
        if (wr_c && rd_c == a) begin
            m = merge({16'h0, ref_mc[a]}, {16'h0, wdata_c}, {2'b00, be_c});
            return m[15:0];
        end
        return ref_mc[a];
    endfunction

    function automatic logic exp_busy_c(input logic [2:0] a);
        if (!rst_n) return 1'b0;
        if (a == 3'd0) return 1'b0;
        if (wr_c && rd_c == a) return (claim_c && caddr_c == a) ? ref_bc[a] : 1'b0;
        return ref_bc[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) begin
            ref_ma[i] = '0; ref_mb[i] = '0; ref_ba[i] = 1'b0; ref_bb[i] = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            ref_mc[i] = '0; ref_bc[i] = 1'b0;
        end
    endtask

    // Advance one rising edge and apply the architectural update rules.
    task automatic step();
        logic [31:0] m;
        @(posedge clk);
        if (rst_n) begin
            if (wr && rd != 5'd0) begin
                ref_ma[rd] = merge(ref_ma[rd], wdata, be);
                ref_ba[rd] = 1'b0;
            end
            if (wr) begin
                ref_mb[rd] = merge(ref_mb[rd], wdata, be);
                ref_bb[rd] = 1'b0;
            end
            if (claim && caddr != 5'd0) ref_ba[caddr] = 1'b1;
            if (claim) ref_bb[caddr] = 1'b1;
            if (wr_c && rd_c != 3'd0) begin
                m = merge({16'h0, ref_mc[rd_c]}, {16'h0, wdata_c}, {2'b00, be_c});
                ref_mc[rd_c] = m[15:0];
                ref_bc[rd_c] = 1'b0;
            end
            if (claim_c && caddr_c != 3'd0) ref_bc[caddr_c] = 1'b1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        wr = 0; claim = 0; rd = 0; caddr = 0; wdata = 0; be = 4'hF;
        wr_c = 0; claim_c = 0; rd_c = 0; caddr_c = 0; wdata_c = 0; be_c = 2'b11;
        r1_c = 0; r2_c = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 0; idle_inputs(); r1 = 5'd1; r2 = 5'd31;
        clear_model();
        step(); step();
        if (oa1 !== 32'h0) begin errors++; $display("FAIL reset_out1 got %h exp 0", oa1); end
        checks++;
        if (oa2 !== 32'h0) begin errors++; $display("FAIL reset_out2 got %h exp 0", oa2); end
        checks++;
        if (ba1 !== 1'b0 || ba2 !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b%b exp 00", ba1, ba2);
        end
        checks++;
        rst_n = 1; #1;
        if (oa1 !== 32'h0 || ob2 !== 32'h0) begin
            errors++; $display("FAIL reset_release got %h/%h exp 0/0", oa1, ob2);
        end
        checks++;
    endtask

    task automatic test_write_bypass();
        wr = 1; rd = 5'd3; be = 4'hF; wdata = 32'd7; r1 = 5'd3; r2 = 5'd2; #1;
        if (oa1 !== 32'd7) begin errors++; $display("FAIL bypass_out1 got %h exp 7", oa1); end
        checks++;
        step(); wr = 0; #1;
        if (oa1 !== 32'd7) begin errors++; $display("FAIL stored_out1 got %h exp 7", oa1); end
        checks++;
        if (oa2 !== 32'd0) begin errors++; $display("FAIL other_out2 got %h exp 0", oa2); end
        checks++;
    endtask

    task automatic test_byte_enable();
        wr = 1; rd = 5'd4; be = 4'hF; wdata = 32'h11223344; r1 = 5'd4;
        step();
        be = 4'b0101; wdata = 32'hAABBCCDD; #1;
        if (oa1 !== 32'h11BB33DD) begin errors++; $display("FAIL be_bypass got %h exp 11bb33dd", oa1); end
        checks++;
        step(); wr = 0; be = 4'hF; #1;
        if (oa1 !== 32'h11BB33DD) begin errors++; $display("FAIL be_stored got %h exp 11bb33dd", oa1); end
        checks++;
    endtask

    task automatic test_zero_reg();
        wr = 1; rd = 5'd0; wdata = 32'hFFFFFFFF; be = 4'hF; claim = 1; caddr = 5'd0; r1 = 5'd0; #1;
        if (oa1 !== 32'h0 || ba1 !== 1'b0) begin
            errors++; $display("FAIL zero_during got %h/%b exp 0/0", oa1, ba1);
        end
        checks++;
        if (ob1 !== 32'hFFFFFFFF) begin errors++; $display("FAIL nozero_bypass got %h exp ffffffff", ob1); end
        checks++;
        step(); wr = 0; claim = 0; #1;
        if (oa1 !== 32'h0 || ba1 !== 1'b0) begin
            errors++; $display("FAIL zero_after got %h/%b exp 0/0", oa1, ba1);
        end
        checks++;
        if (ob1 !== 32'hFFFFFFFF || bb1 !== 1'b1) begin
            errors++; $display("FAIL nozero_after got %h/%b exp ffffffff/1", ob1, bb1);
        end
        checks++;
    endtask

    task automatic test_scoreboard();
        claim = 1; caddr = 5'd8; r1 = 5'd8; #1;
        if (ba1 !== 1'b0) begin errors++; $display("FAIL claim_cycle got %b exp 0", ba1); end
        checks++;
        step(); claim = 0; #1;
        if (ba1 !== 1'b1) begin errors++; $display("FAIL claim_after got %b exp 1", ba1); end
        checks++;
        step();
        wr = 1; rd = 5'd8; be = 4'hF; wdata = 32'h55; #1;
        if (ba1 !== 1'b0 || oa1 !== 32'h55) begin
            errors++; $display("FAIL retire_cycle got %b/%h exp 0/55", ba1, oa1);
        end
        checks++;
        step(); wr = 0; #1;
        if (ba1 !== 1'b0 || oa1 !== 32'h55) begin
            errors++; $display("FAIL retire_after got %b/%h exp 0/55", ba1, oa1);
        end
        checks++;
    endtask

    task automatic test_collision();
        claim = 1; caddr = 5'd9; wr = 1; rd = 5'd9; be = 4'hF; wdata = 32'h1; r2 = 5'd9;
        step(); claim = 0; wr = 0; #1;
        if (ba2 !== 1'b1 || oa2 !== 32'h1) begin
            errors++; $display("FAIL collision got %b/%h exp 1/1", ba2, oa2);
        end
        checks++;
    endtask

    task automatic test_mid_reset();
        wr = 1; rd = 5'd5; be = 4'hF; wdata = 32'hDEAD; r1 = 5'd5;
        step(); wr = 0; #1;
        if (oa1 !== 32'hDEAD) begin errors++; $display("FAIL pre_reset got %h exp dead", oa1); end
        checks++;
        rst_n = 0; clear_model(); #1;
        if (oa1 !== 32'h0) begin errors++; $display("FAIL async_reset got %h exp 0", oa1); end
        checks++;
        wr = 1; rd = 5'd6; wdata = 32'h1234; claim = 1; caddr = 5'd6;
        step();
        rst_n = 1; wr = 0; claim = 0; r1 = 5'd6; #1;
        if (oa1 !== 32'h0 || ba1 !== 1'b0) begin
            errors++; $display("FAIL reset_edge_drop got %h/%b exp 0/0", oa1, ba1);
        end
        checks++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 300; it++) begin
            wr = 1'($urandom); claim = 1'($urandom);
            rd = 5'($urandom_range(0, 11)); caddr = 5'($urandom_range(0, 11));
            r1 = 5'($urandom_range(0, 11)); r2 = 5'($urandom_range(0, 11));
            wdata = $urandom; be = 4'($urandom);
            wr_c = 1'($urandom); claim_c = 1'($urandom);
            rd_c = 3'($urandom); caddr_c = 3'($urandom);
            r1_c = 3'($urandom); r2_c = 3'($urandom);
            wdata_c = 16'($urandom); be_c = 2'($urandom);
            #1;
            if (oa1 !== exp_out_ab(1, r1)) begin errors++; $display("FAIL rnd_a_out1 it=%0d got %h exp %h", it, oa1, exp_out_ab(1, r1)); end
            checks++;
            if (oa2 !== exp_out_ab(1, r2)) begin errors++; $display("FAIL rnd_a_out2 it=%0d got %h exp %h", it, oa2, exp_out_ab(1, r2)); end
            checks++;
            if (ba1 !== exp_busy_ab(1, r1)) begin errors++; $display("FAIL rnd_a_busy1 it=%0d got %b exp %b", it, ba1, exp_busy_ab(1, r1)); end
            checks++;
            if (ba2 !== exp_busy_ab(1, r2)) begin errors++; $display("FAIL rnd_a_busy2 it=%0d got %b exp %b", it, ba2, exp_busy_ab(1, r2)); end
            checks++;
            if (ob1 !== exp_out_ab(0, r1)) begin errors++; $display("FAIL rnd_b_out1 it=%0d got %h exp %h", it, ob1, exp_out_ab(0, r1)); end
            checks++;
            if (ob2 !== exp_out_ab(0, r2)) begin errors++; $display("FAIL rnd_b_out2 it=%0d got %h exp %h", it, ob2, exp_out_ab(0, r2)); end
            checks++;
            if (bb1 !== exp_busy_ab(0, r1)) begin errors++; $display("FAIL rnd_b_busy1 it=%0d got %b exp %b", it, bb1, exp_busy_ab(0, r1)); end
            checks++;
            if (bb2 !== exp_busy_ab(0, r2)) begin errors++; $display("FAIL rnd_b_busy2 it=%0d got %b exp %b", it, bb2, exp_busy_ab(0, r2)); end
            checks++;
            if (oc1 !== exp_out_c(r1_c)) begin errors++; $display("FAIL rnd_c_out1 it=%0d got %h exp %h", it, oc1, exp_out_c(r1_c)); end
            checks++;
            if (oc2 !== exp_out_c(r2_c)) begin errors++; $display("FAIL rnd_c_out2 it=%0d got %h exp %h", it, oc2, exp_out_c(r2_c)); end
            checks++;
            if (bc1 !== exp_busy_c(r1_c)) begin errors++; $display("FAIL rnd_c_busy1 it=%0d got %b exp %b", it, bc1, exp_busy_c(r1_c)); end
            checks++;
            if (bc2 !== exp_busy_c(r2_c)) begin errors++; $display("FAIL rnd_c_busy2 it=%0d got %b exp %b", it, bc2, exp_busy_c(r2_c)); end
            checks++;
            step();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_byte_enable();
        test_zero_reg();
        test_scoreboard();
        test_collision();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
